// File: rtl/busctl_pkg.sv
// Shared types for the multi-master bus controller: FSM state encodings
// and the address-decode destination.
package busctl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MEM      = 3'd1;
    localparam state_t ST_MEM_WAIT = 3'd2;
    localparam state_t ST_IO       = 3'd3;
    localparam state_t ST_RESP     = 3'd4;

    typedef enum logic [1:0] {
        DST_MEM,
        DST_IO,
        DST_NONE
    } dst_t;

endpackage

// File: rtl/busctl_mm_if.sv
// Bundle of master-side, memctl-side and MMIO-side signals of busctl_mm.
// The slave modport is the controller's view; master is the environment's.
interface busctl_mm_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8
);

    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_ack;
    logic [DATA_W-1:0]           m_rdata;
    logic                        m_err;

    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    logic                        io_valid;
    logic                        io_we;
    logic [ADDR_W-1:0]           io_addr;
    logic [DATA_W-1:0]           io_wdata;
    logic                        io_ready;
    logic [DATA_W-1:0]           io_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata, m_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output io_valid, io_we, io_addr, io_wdata,
        input  io_ready, io_rdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata, m_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  io_valid, io_we, io_addr, io_wdata,
        output io_ready, io_rdata
    );

endinterface

// File: rtl/busctl_mm_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; the pointer
// moves to the winner only when advance is high and someone was granted.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req,
    input  logic [N-1:0]                         mask,
    input  logic                                 advance,
    output logic [N-1:0]                         grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] index,
    output logic                                 any
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     eligible;

    assign eligible = req & ~mask;

    always_comb begin
        int unsigned c;
        c     = 0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            c = (32'(ptr) + i) % N;
            if (!any && eligible[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                index    = IDX_W'(c);
            end
        end
    end

    // Reset pointer at N-1 so master 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_W'(N - 1);
        end else if (advance && any) begin
            ptr <= index;
        end
    end

endmodule

// File: rtl/busctl_mm.sv
// Multi-master bus controller: round-robin grant, address decode to memctl,
// MMIO (valid/ready with timeout) or an error response; one transfer at a time.
module busctl_mm
    import busctl_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_SIZE  = 'h10000,
    parameter int unsigned IO_BASE   = 'h10000,
    parameter int unsigned IO_SIZE   = 'h100,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic      clk,
    input logic      rst,
    busctl_mm_if.slave bus
);

    localparam int unsigned IDX_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned CNT_MAX = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Region bounds carry one extra bit so IO_BASE+IO_SIZE cannot wrap.
    localparam logic [ADDR_W:0] MEM_END = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [ADDR_W:0] IO_LO   = (ADDR_W + 1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_HI   = (ADDR_W + 1)'(IO_BASE) + (ADDR_W + 1)'(IO_SIZE);

    function automatic dst_t decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        if (ax < MEM_END) begin
            return DST_MEM;
        end else if (ax >= IO_LO && ax < IO_HI) begin
            return DST_IO;
        end else begin
            return DST_NONE;
        end
    endfunction

    state_t                 state;
    logic [N_MASTERS-1:0]   win_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [N_MASTERS-1:0]   acked_q;
    logic [N_MASTERS-1:0]   ack;

    logic [N_MASTERS-1:0]   grant;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    dst_t                   sel_dst;
    logic                   in_mem;
    logic                   in_io;

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.m_req),
        .mask    (acked_q),
        .advance (state == ST_IDLE),
        .grant   (grant),
        .index   (gnt_idx),
        .any     (gnt_any)
    );

    assign sel_we    = bus.m_we[gnt_idx];
    assign sel_addr  = bus.m_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.m_wdata[gnt_idx*DATA_W +: DATA_W];
    assign sel_dst   = decode(sel_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            acked_q <= '0;
        end else begin
            acked_q <= ack;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        win_q   <= grant;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt_q   <= '0;
                        case (sel_dst)
                            DST_MEM: state <= ST_MEM;
                            DST_IO:  state <= ST_IO;
                            default: begin
                                state   <= ST_RESP;
                                err_q   <= 1'b1;
                                rdata_q <= '0;
                            end
                        endcase
                    end
                end
                ST_MEM: begin
                    if (we_q) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end else begin
                        state <= ST_MEM_WAIT;
                        cnt_q <= CNT_W'(MEM_LAT - 1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt_q == '0) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= bus.mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_IO: begin
                    if (bus.io_ready) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : bus.io_rdata;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ack    = (state == ST_RESP) ? win_q : '0;
    assign in_mem = (state == ST_MEM) || (state == ST_MEM_WAIT);
    assign in_io  = (state == ST_IO);

    assign bus.m_ack   = ack;
    assign bus.m_rdata = rdata_q;
    assign bus.m_err   = err_q;

    assign bus.mem_we    = (state == ST_MEM) && we_q;
    assign bus.mem_addr  = in_mem ? addr_q : '0;
    assign bus.mem_wdata = in_mem ? wdata_q : '0;

    assign bus.io_valid = in_io;
    assign bus.io_we    = in_io && we_q;
    assign bus.io_addr  = in_io ? addr_q : '0;
    assign bus.io_wdata = in_io ? wdata_q : '0;

endmodule

// File: tb/tb_busctl_mm.sv
// Directed bench for busctl_mm with a small memctl model (latency 1,
// contents reset to addr^0x5A) and an MMIO target driven by the scenarios.
module tb_busctl_mm;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    busctl_mm_if #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    busctl_mm #(
        .N_MASTERS (NM),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_SIZE  ('h10000),
        .IO_BASE   ('h10000),
        .IO_SIZE   ('h100),
        .MEM_LAT   (1),
        .TIMEOUT   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_rd;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 8'h5A;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        mem_rd <= mem[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = mem_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.m_we[m]              = we;
        bus.m_addr[m*AW +: AW]   = a;
        bus.m_wdata[m*DW +: DW]  = d;
    endtask

    task automatic wait_ack(input int budget, output logic [NM-1:0] ack, output int cyc);
        ack = '0;
        cyc = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (bus.m_ack != '0) begin
                ack = bus.m_ack;
                break;
            end
        end
    endtask

    task automatic go_idle();
        bus.m_req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_req = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
        bus.io_ready = 1'b0; bus.io_rdata = '0;
        tick(); tick();
        n_cmp++; if (bus.m_ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", bus.m_ack); end
        n_cmp++; if ({bus.m_err, bus.m_rdata} !== 9'h000) begin n_bad++; $display("FAIL reset_resp: got err=%b rdata=%h want 0/00", bus.m_err, bus.m_rdata); end
        n_cmp++; if ({bus.mem_we, bus.io_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got mem_we=%b io_valid=%b want 0/0", bus.mem_we, bus.io_valid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mem_wr_rd();
        set_m(0, 1'b1, 17'h00042, 8'hA5);
        bus.m_req = 2'b01;
        tick();
        n_cmp++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'h00042, 8'hA5})
            begin n_bad++; $display("FAIL memwr_cyc1: got we=%b a=%h d=%h want 1/00042/a5", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        tick();
        n_cmp++; if ({bus.m_ack, bus.m_err, bus.m_rdata} !== {2'b01, 1'b0, 8'h00})
            begin n_bad++; $display("FAIL memwr_ack_cyc2: got ack=%b err=%b rd=%h want 01/0/00", bus.m_ack, bus.m_err, bus.m_rdata); end
        go_idle();
        set_m(0, 1'b0, 17'h00042, 8'h00);
        bus.m_req = 2'b01;
        tick();
        n_cmp++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, 17'h00042})
            begin n_bad++; $display("FAIL memrd_cyc1: got we=%b a=%h want 0/00042", bus.mem_we, bus.mem_addr); end
        tick();
        n_cmp++; if ({bus.m_ack, bus.mem_addr} !== {2'b00, 17'h00042})
            begin n_bad++; $display("FAIL memrd_cyc2: got ack=%b a=%h want 00/00042", bus.m_ack, bus.mem_addr); end
        tick();
        n_cmp++; if ({bus.m_ack, bus.m_err, bus.m_rdata} !== {2'b01, 1'b0, 8'hA5})
            begin n_bad++; $display("FAIL memrd_ack_cyc3: got ack=%b err=%b rd=%h want 01/0/a5", bus.m_ack, bus.m_err, bus.m_rdata); end
        go_idle();
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] ack;
        logic [NM-1:0] exp_ack;
        logic [DW-1:0] exp_rd;
        int cyc;
        int exp_cyc;
        set_m(0, 1'b0, 17'h00010, 8'h00);
        set_m(1, 1'b0, 17'h00020, 8'h00);
        bus.m_req = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd  = (k % 2 == 0) ? 8'h4A : 8'h7A;
            exp_cyc = (k == 0) ? 3 : 4;
            wait_ack(12, ack, cyc);
            n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL rr_order[%0d]: got %b want %b", k, ack, exp_ack); end
            n_cmp++; if (cyc !== exp_cyc) begin n_bad++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, cyc, exp_cyc); end
            n_cmp++; if (bus.m_rdata !== exp_rd) begin n_bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, bus.m_rdata, exp_rd); end
        end
        // Only master 0 keeps requesting: immediate re-grant, then one masked IDLE.
        bus.m_req = 2'b01;
        wait_ack(12, ack, cyc);
        n_cmp++; if ({ack, 8'(cyc)} !== {2'b01, 8'd4}) begin n_bad++; $display("FAIL solo_first: got ack=%b gap=%0d want 01/4", ack, cyc); end
        wait_ack(12, ack, cyc);
        n_cmp++; if ({ack, 8'(cyc)} !== {2'b01, 8'd5}) begin n_bad++; $display("FAIL solo_masked: got ack=%b gap=%0d want 01/5", ack, cyc); end
        go_idle();
    endtask

    task automatic test_io_read();
        set_m(1, 1'b0, 17'h10010, 8'h00);
        bus.m_req = 2'b10;
        tick();
        n_cmp++; if ({bus.io_valid, bus.io_we, bus.io_addr, bus.mem_we} !== {1'b1, 1'b0, 17'h10010, 1'b0})
            begin n_bad++; $display("FAIL io_cyc1: got v=%b we=%b a=%h mwe=%b want 1/0/10010/0", bus.io_valid, bus.io_we, bus.io_addr, bus.mem_we); end
        tick();
        tick();
        bus.io_ready = 1'b1;
        bus.io_rdata = 8'h3C;
        n_cmp++; if ({bus.io_valid, bus.m_ack} !== {1'b1, 2'b00})
            begin n_bad++; $display("FAIL io_cyc3: got v=%b ack=%b want 1/00", bus.io_valid, bus.m_ack); end
        tick();
        bus.io_ready = 1'b0;
        bus.io_rdata = 8'h00;
        n_cmp++; if ({bus.m_ack, bus.m_err, bus.m_rdata, bus.io_valid} !== {2'b10, 1'b0, 8'h3C, 1'b0})
            begin n_bad++; $display("FAIL io_ack: got ack=%b err=%b rd=%h v=%b want 10/0/3c/0", bus.m_ack, bus.m_err, bus.m_rdata, bus.io_valid); end
        go_idle();
    endtask

    task automatic test_io_timeout();
        logic [NM-1:0] ack;
        int  vcnt;
        logic fields_ok;
        vcnt = 0;
        ack = '0;
        fields_ok = 1'b1;
        set_m(0, 1'b1, 17'h10005, 8'h77);
        bus.m_req = 2'b01;
        bus.io_ready = 1'b0;
        for (int c = 0; c < 30 && ack == '0; c++) begin
            tick();
            if (bus.io_valid) begin
                vcnt++;
                if (bus.io_we !== 1'b1 || bus.io_wdata !== 8'h77 || bus.io_addr !== 17'h10005) fields_ok = 1'b0;
            end
            if (bus.m_ack != '0) ack = bus.m_ack;
        end
        n_cmp++; if (vcnt !== 16) begin n_bad++; $display("FAIL to_valid_cycles: got %0d want 16", vcnt); end
        n_cmp++; if (fields_ok !== 1'b1) begin n_bad++; $display("FAIL to_io_fields: got %b want 1", fields_ok); end
        n_cmp++; if ({ack, bus.m_err, bus.m_rdata} !== {2'b01, 1'b1, 8'h00})
            begin n_bad++; $display("FAIL to_resp: got ack=%b err=%b rd=%h want 01/1/00", ack, bus.m_err, bus.m_rdata); end
        go_idle();
    endtask

    task automatic test_decode();
        logic [AW-1:0] addrs [6];
        int            exp_code [6];
        logic [NM-1:0] ack;
        int cyc;
        int code;
        // 0 = memory, 1 = IO, 2 = unmapped (immediate error ack)
        addrs = '{17'h0FFFF, 17'h10000, 17'h100FF, 17'h10100, 17'h1FFFF, 17'h00010};
        exp_code = '{0, 1, 1, 2, 2, 0};
        for (int i = 0; i < 6; i++) begin
            set_m(0, 1'b0, addrs[i], 8'h00);
            bus.m_req = 2'b01;
            tick();
            code = bus.io_valid ? 1 : ((bus.m_ack != '0) ? 2 : 0);
            n_cmp++; if (code !== exp_code[i]) begin n_bad++; $display("FAIL decode[%h]: got %0d want %0d", addrs[i], code, exp_code[i]); end
            if (code == 1) begin
                bus.io_ready = 1'b1;
                bus.io_rdata = 8'h11;
            end
            if (code != 2) wait_ack(25, ack, cyc);
            bus.io_ready = 1'b0;
            go_idle();
        end
        n_cmp++; if ({bus.m_err, bus.m_rdata} !== {1'b0, 8'h4A})
            begin n_bad++; $display("FAIL decode_last_rd: got err=%b rd=%h want 0/4a", bus.m_err, bus.m_rdata); end
    endtask

    task automatic test_unmapped();
        set_m(1, 1'b0, 17'h10200, 8'h00);
        bus.m_req = 2'b10;
        tick();
        n_cmp++; if ({bus.m_ack, bus.m_err, bus.m_rdata} !== {2'b10, 1'b1, 8'h00})
            begin n_bad++; $display("FAIL unmapped_ack: got ack=%b err=%b rd=%h want 10/1/00", bus.m_ack, bus.m_err, bus.m_rdata); end
        n_cmp++; if ({bus.mem_we, bus.io_valid} !== 2'b00)
            begin n_bad++; $display("FAIL unmapped_strobes: got mwe=%b v=%b want 0/0", bus.mem_we, bus.io_valid); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic [NM-1:0] ack;
        int cyc;
        set_m(0, 1'b0, 17'h10005, 8'h00);
        bus.m_req = 2'b01;
        bus.io_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.io_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got io_valid=%b want 1", bus.io_valid); end
        rst = 1'b1;
        set_m(0, 1'b0, 17'h00010, 8'h00);
        set_m(1, 1'b0, 17'h00020, 8'h00);
        bus.m_req = 2'b11;
        tick();
        n_cmp++; if ({bus.io_valid, bus.m_ack, bus.mem_we} !== {1'b0, 2'b00, 1'b0})
            begin n_bad++; $display("FAIL rstmid_drop: got v=%b ack=%b mwe=%b want 0/00/0", bus.io_valid, bus.m_ack, bus.mem_we); end
        rst = 1'b0;
        wait_ack(12, ack, cyc);
        n_cmp++; if ({ack, 8'(cyc), bus.m_rdata} !== {2'b01, 8'd3, 8'h4A})
            begin n_bad++; $display("FAIL rstmid_first_grant: got ack=%b cyc=%0d rd=%h want 01/3/4a", ack, cyc, bus.m_rdata); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_mem_wr_rd();
        test_round_robin();
        test_io_read();
        test_io_timeout();
        test_decode();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
